// File: rtl/fifo_bank_pkg.sv
// ---------------------------------------------------------------------------
// fifo_bank_pkg
// Shared constants for the FIFO bank and the round-robin arbiter it feeds.
//   QUEUE_QUANTITY_DEF / DATA_BITS_DEF / BUF_WIDTH_DEF : default geometry
//   SEL_W / CNT_W                                      : derived widths
//   ALMOST_FULL_LVL_DEF : default threshold, used only when
//                         FIFO_BANK_ALMOST_FULL_EN is defined
// ---------------------------------------------------------------------------
package fifo_bank_pkg;

    localparam int QUEUE_QUANTITY_DEF  = 4;
    localparam int DATA_BITS_DEF       = 8;
    localparam int BUF_WIDTH_DEF       = 3;
    localparam int ALMOST_FULL_LVL_DEF = 6;

    // A selector must be at least one bit wide even for a single queue.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SEL_W = sel_width(QUEUE_QUANTITY_DEF);
    localparam int CNT_W = BUF_WIDTH_DEF + 1;

endpackage

// File: rtl/fifo_bank_if.sv
// ---------------------------------------------------------------------------
// fifo_bank_if
// Push/pop/status bundle between upstream logic + arbiter (master) and the
// FIFO bank (slave).
//   master drives : enb, wr_en, wr_sel, data_in, selector, selector_enb
//   slave drives  : buf_empty, buf_full, data_out, data_out_valid, wr_drop
//                   (+ almost_full when FIFO_BANK_ALMOST_FULL_EN is defined)
// ---------------------------------------------------------------------------
interface fifo_bank_if
    import fifo_bank_pkg::*;
#(
    parameter int QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
    parameter int DATA_BITS      = DATA_BITS_DEF
) ();

    localparam int SW = sel_width(QUEUE_QUANTITY);

    logic                      enb;
    logic                      wr_en;
    logic [SW-1:0]             wr_sel;
    logic [DATA_BITS-1:0]      data_in;
    logic [SW-1:0]             selector;
    logic                      selector_enb;
    logic [QUEUE_QUANTITY-1:0] buf_empty;
    logic [QUEUE_QUANTITY-1:0] buf_full;
    logic [DATA_BITS-1:0]      data_out;
    logic                      data_out_valid;
    logic                      wr_drop;
`ifdef FIFO_BANK_ALMOST_FULL_EN
    logic [QUEUE_QUANTITY-1:0] almost_full;
`endif

    modport master (
        output enb, wr_en, wr_sel, data_in, selector, selector_enb,
        input  buf_empty, buf_full, data_out, data_out_valid, wr_drop
`ifdef FIFO_BANK_ALMOST_FULL_EN
        , input almost_full
`endif
    );

    modport slave (
        input  enb, wr_en, wr_sel, data_in, selector, selector_enb,
        output buf_empty, buf_full, data_out, data_out_valid, wr_drop
`ifdef FIFO_BANK_ALMOST_FULL_EN
        , output almost_full
`endif
    );

endinterface

// File: rtl/fifo_bank_single.sv
// ---------------------------------------------------------------------------
// fifo_single
// One circular FIFO of 2^BUF_WIDTH words: storage, pointers, occupancy count
// and the same-queue push+pop rules.
//   clk, rst        : clock, asynchronous active-high reset
//   push_req_i      : push requested for this queue (already enb-gated)
//   pop_req_i       : pop requested for this queue (already enb-gated)
//   data_i          : word to push
//   push_ok_o       : push accepted this cycle
//   pop_ok_o        : pop accepted this cycle
//   head_o          : word at the read pointer
//   empty_o/full_o  : decoded from the registered count only
//   almost_full_o   : count >= ALMOST_FULL_LVL (FIFO_BANK_ALMOST_FULL_EN)
// ---------------------------------------------------------------------------
module fifo_single
    import fifo_bank_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int BUF_WIDTH = BUF_WIDTH_DEF
`ifdef FIFO_BANK_ALMOST_FULL_EN
    , parameter int ALMOST_FULL_LVL = ALMOST_FULL_LVL_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_req_i,
    input  logic                 pop_req_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 push_ok_o,
    output logic                 pop_ok_o,
    output logic [DATA_BITS-1:0] head_o,
    output logic                 empty_o,
    output logic                 full_o
`ifdef FIFO_BANK_ALMOST_FULL_EN
    , output logic               almost_full_o
`endif
);

    localparam int                 DEPTH    = 1 << BUF_WIDTH;
    localparam logic [BUF_WIDTH:0] FULL_CNT = {1'b1, {BUF_WIDTH{1'b0}}};

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [BUF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_WIDTH:0]   count_q, count_d;
    logic                 push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_req_i && (count_q != '0);
        // A full queue still takes a push when the same cycle frees a slot.
        push_ok  = push_req_i && ((count_q != FULL_CNT) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign push_ok_o = push_ok;
    assign pop_ok_o  = pop_ok;
    assign head_o    = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);

`ifdef FIFO_BANK_ALMOST_FULL_EN
    localparam logic [BUF_WIDTH:0] AF_CNT = (BUF_WIDTH + 1)'(ALMOST_FULL_LVL);
    assign almost_full_o = (count_q >= AF_CNT);
`endif

endmodule

// File: rtl/fifo_bank.sv
// ---------------------------------------------------------------------------
// fifo_bank
// QUEUE_QUANTITY independent FIFOs written by upstream logic and drained by
// the weighted round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_bank_if.slave (push, pop, per-queue status, registered
//              data_out/data_out_valid, wr_drop pulse)
// Optional: define FIFO_BANK_ALMOST_FULL_EN to add parameter ALMOST_FULL_LVL
// and the per-queue bus.almost_full status.
// ---------------------------------------------------------------------------
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
    parameter int DATA_BITS      = DATA_BITS_DEF,
    parameter int BUF_WIDTH      = BUF_WIDTH_DEF
`ifdef FIFO_BANK_ALMOST_FULL_EN
    , parameter int ALMOST_FULL_LVL = ALMOST_FULL_LVL_DEF
`endif
) (
    input logic        clk,
    input logic        rst,
    fifo_bank_if.slave bus
);

    localparam int SW = sel_width(QUEUE_QUANTITY);

    logic [QUEUE_QUANTITY-1:0] push_ok, pop_ok, empty_w, full_w;
    logic [DATA_BITS-1:0]      head [QUEUE_QUANTITY];
    logic [DATA_BITS-1:0]      data_out_q, data_out_d;
    logic                      valid_q, valid_d;
    logic                      drop_q, drop_d;
`ifdef FIFO_BANK_ALMOST_FULL_EN
    logic [QUEUE_QUANTITY-1:0] af_w;
`endif

    for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_q
        fifo_single #(
            .DATA_BITS       (DATA_BITS),
            .BUF_WIDTH       (BUF_WIDTH)
`ifdef FIFO_BANK_ALMOST_FULL_EN
            , .ALMOST_FULL_LVL (ALMOST_FULL_LVL)
`endif
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_req_i (bus.enb && bus.wr_en && (bus.wr_sel == SW'(g))),
            .pop_req_i  (bus.enb && bus.selector_enb && (bus.selector == SW'(g))),
            .data_i     (bus.data_in),
            .push_ok_o  (push_ok[g]),
            .pop_ok_o   (pop_ok[g]),
            .head_o     (head[g]),
            .empty_o    (empty_w[g]),
            .full_o     (full_w[g])
`ifdef FIFO_BANK_ALMOST_FULL_EN
            , .almost_full_o (af_w[g])
`endif
        );
    end

    always_comb begin
        data_out_d = data_out_q;
        valid_d    = |pop_ok;
        // Only one queue is addressed per cycle, so any accepted push is ours.
        drop_d     = bus.enb && bus.wr_en && !(|push_ok);
        if (|pop_ok) data_out_d = head[bus.selector];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.buf_empty      = empty_w;
    assign bus.buf_full       = full_w;
    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = valid_q;
    assign bus.wr_drop        = drop_q;
`ifdef FIFO_BANK_ALMOST_FULL_EN
    assign bus.almost_full    = af_w;
`endif

endmodule

// File: tb/tb_fifo_bank.sv
// ---------------------------------------------------------------------------
// tb_fifo_bank
// Directed bench for fifo_bank (4 queues x 8 words x 8 bits). A table of
// per-cycle stimulus with expected post-edge outputs, plus hand sequences for
// asynchronous reset and, with FIFO_BANK_ALMOST_FULL_EN, the almost_full flag.
// ---------------------------------------------------------------------------
module tb_fifo_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_bank_if #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) bus ();

    fifo_bank #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .BUF_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       enb;
        logic       wr_en;
        logic [1:0] wr_sel;
        logic [7:0] din;
        logic       pop;
        logic [1:0] sel;
        logic [7:0] exp_dout;
        logic       exp_vld;
        logic [3:0] exp_empty;
        logic [3:0] exp_full;
        logic       exp_drop;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void add(input logic e, input logic we, input logic [1:0] ws,
                                input logic [7:0] d, input logic p, input logic [1:0] s,
                                input logic [7:0] xd, input logic xv, input logic [3:0] xe,
                                input logic [3:0] xf, input logic xdr);
        vec_t v;
        v.enb = e; v.wr_en = we; v.wr_sel = ws; v.din = d; v.pop = p; v.sel = s;
        v.exp_dout = xd; v.exp_vld = xv; v.exp_empty = xe; v.exp_full = xf;
        v.exp_drop = xdr;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.enb          = v.enb;
        bus.wr_en        = v.wr_en;
        bus.wr_sel       = v.wr_sel;
        bus.data_in      = v.din;
        bus.selector_enb = v.pop;
        bus.selector     = v.sel;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " dout"},  32'(bus.data_out),       32'(v.exp_dout));
        chk({tag, " vld"},   32'(bus.data_out_valid), 32'(v.exp_vld));
        chk({tag, " empty"}, 32'(bus.buf_empty),      32'(v.exp_empty));
        chk({tag, " full"},  32'(bus.buf_full),       32'(v.exp_full));
        chk({tag, " drop"},  32'(bus.wr_drop),        32'(v.exp_drop));
    endtask

    // Apply one vector, let one rising edge pass, then sample 1 unit later.
    task automatic step(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    task automatic step_last(input string tag);
        vec_t v;
        v = vq.pop_back();
        step(tag, v);
    endtask

    initial begin
        vec_t v;

        // ---------------- table construction ----------------
        // 1: three words through q2
        add(1,1,2,8'h11, 0,0, 8'h00,0,4'b1011,4'b0000,0);
        add(1,1,2,8'h22, 0,0, 8'h00,0,4'b1011,4'b0000,0);
        add(1,1,2,8'h33, 0,0, 8'h00,0,4'b1011,4'b0000,0);
        add(1,0,0,8'h00, 1,2, 8'h11,1,4'b1011,4'b0000,0);
        add(1,0,0,8'h00, 1,2, 8'h22,1,4'b1011,4'b0000,0);
        add(1,0,0,8'h00, 1,2, 8'h33,1,4'b1111,4'b0000,0);
        // 2: fill q1, overflow push, drain with pointer wrap
        for (int i = 0; i < 8; i++)
            add(1,1,1,8'hA0 + 8'(i), 0,0, 8'h33,0,4'b1101,
                (i == 7) ? 4'b0010 : 4'b0000, 0);
        add(1,1,1,8'hA8, 0,0, 8'h33,0,4'b1101,4'b0010,1);
        add(1,0,0,8'h00, 0,0, 8'h33,0,4'b1101,4'b0010,0);
        for (int i = 0; i < 8; i++)
            add(1,0,0,8'h00, 1,1, 8'hA0 + 8'(i),1,
                (i == 7) ? 4'b1111 : 4'b1101, 4'b0000, 0);
        // 3: full q3 push+pop, then drain to see 0xAA at the tail
        for (int i = 0; i < 8; i++)
            add(1,1,3,8'hB0 + 8'(i), 0,0, 8'hA7,0,4'b0111,
                (i == 7) ? 4'b1000 : 4'b0000, 0);
        add(1,1,3,8'hAA, 1,3, 8'hB0,1,4'b0111,4'b1000,0);
        for (int i = 0; i < 8; i++)
            add(1,0,0,8'h00, 1,3, (i < 7) ? 8'hB1 + 8'(i) : 8'hAA, 1,
                (i == 7) ? 4'b1111 : 4'b0111, 4'b0000, 0);
        //    empty q0 push+pop: pop ignored, word stored
        add(1,1,0,8'h55, 1,0, 8'hAA,0,4'b1110,4'b0000,0);
        add(1,0,0,8'h00, 1,0, 8'h55,1,4'b1111,4'b0000,0);
        // 4: pop of empty queue, then enb low ignores push and pop
        add(1,0,0,8'h00, 1,1, 8'h55,0,4'b1111,4'b0000,0);
        add(1,1,2,8'h66, 0,0, 8'h55,0,4'b1011,4'b0000,0);
        add(0,1,2,8'h77, 1,2, 8'h55,0,4'b1011,4'b0000,0);
        add(1,0,0,8'h00, 1,2, 8'h66,1,4'b1111,4'b0000,0);
        add(1,0,0,8'h00, 0,0, 8'h66,0,4'b1111,4'b0000,0);

        // ---------------- reset state ----------------
        bus.enb = 1'b0; bus.wr_en = 1'b0; bus.wr_sel = '0; bus.data_in = '0;
        bus.selector_enb = 1'b0; bus.selector = '0;
        #1 rst = 1'b1;
        #2;
        v.exp_dout = 8'h00; v.exp_vld = 0; v.exp_empty = 4'b1111;
        v.exp_full = 4'b0000; v.exp_drop = 0;
        check_outs("reset", v);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        foreach (vq[i]) step($sformatf("v%0d", i), vq[i]);

        // ---------------- 5: async reset mid-burst ----------------
        vq.delete();
        for (int i = 0; i < 5; i++) begin
            add(1,1,0,8'hC0 + 8'(i), 0,0, 8'h66,0,4'b1110,4'b0000,0);
            step_last($sformatf("r_push%0d", i));
        end
        add(1,0,0,8'h00, 1,0, 8'hC0,1,4'b1110,4'b0000,0);
        step_last("r_pop");
        #2 rst = 1'b1;   // mid-cycle, no clock edge involved
        #1;
        v.exp_dout = 8'h00; v.exp_vld = 0; v.exp_empty = 4'b1111;
        v.exp_full = 4'b0000; v.exp_drop = 0;
        check_outs("async_rst", v);
        @(negedge clk);
        rst = 1'b0;
        add(1,0,0,8'h00, 0,0, 8'h00,0,4'b1111,4'b0000,0);
        step_last("post_rst_idle");
        add(1,0,0,8'h00, 1,0, 8'h00,0,4'b1111,4'b0000,0);
        step_last("post_rst_pop");

`ifdef FIFO_BANK_ALMOST_FULL_EN
        // ---------------- 6: almost_full on q0 ----------------
        chk("af_init", 32'(bus.almost_full), 32'h0);
        for (int i = 0; i < 6; i++) begin
            add(1,1,0,8'hD0 + 8'(i), 0,0, 8'h00,0,4'b1110,4'b0000,0);
            step_last($sformatf("af_push%0d", i));
            chk($sformatf("af_after_push%0d", i), 32'(bus.almost_full),
                (i == 5) ? 32'h1 : 32'h0);
        end
        add(1,0,0,8'h00, 1,0, 8'hD0,1,4'b1110,4'b0000,0);
        step_last("af_pop");
        chk("af_after_pop", 32'(bus.almost_full), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
